// File: rtl/alu_cmd_issuer.sv
// Command-side master for the 4-bit ALU: FIFO-buffered commands are driven as packed words,
// held for a settle window, then results return in order. Define ALU_OPCHK_EN for opcode checks.
module alu_cmd_issuer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [3:0]  cmd_a,
  input  logic [3:0]  cmd_b,
  output logic [11:0] alu_in,
  input  logic [3:0]  alu_out,
  input  logic        alu_sign,
  input  logic        alu_carr,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_op,
  output logic [3:0]  rsp_out,
  output logic        rsp_sign,
  output logic        rsp_carr,
  output logic        rsp_zero,
`ifdef ALU_OPCHK_EN
  output logic        rsp_err,
`endif
  output logic        busy,
  output logic [15:0] issued_cnt
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e            state_q, state_d;
  logic [11:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [11:0]       alu_in_q, alu_in_d;
  logic [15:0]       issued_cnt_q, issued_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [3:0]        rsp_op_q, rsp_op_d, rsp_out_q, rsp_out_d;
  logic              rsp_sign_q, rsp_sign_d, rsp_carr_q, rsp_carr_d, rsp_zero_q, rsp_zero_d;
  logic              empty, full, push, pop, rsp_hs;
  logic [11:0]       head;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(FIFO_DEPTH));
  assign push   = cmd_valid && !full;
  assign rsp_hs = rsp_valid_q && rsp_ready;
  assign pop    = !empty && ((state_q == StIdle) || ((state_q == StResp) && rsp_hs));
  assign head   = mem_q[rd_ptr_q];

`ifdef ALU_OPCHK_EN
  logic rsp_err_q, rsp_err_d;
  logic head_legal;

  always_comb begin
    case (head[11:8])
      4'hD, 4'h9, 4'h5, 4'h1, 4'hC, 4'h2, 4'h3, 4'h6: head_legal = 1'b1;
      default:                                         head_legal = 1'b0;
    endcase
  end
`endif

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_in_d     = alu_in_q;
    issued_cnt_d = issued_cnt_q;
    settle_d     = settle_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_out_d    = rsp_out_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_carr_d   = rsp_carr_q;
    rsp_zero_d   = rsp_zero_q;
`ifdef ALU_OPCHK_EN
    rsp_err_d    = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: alu_in_d = 12'h000;
      StDrive: begin
        settle_d = settle_q + SetW'(1);
        if (settle_q == SetW'(SETTLE_CYC - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_op_d    = alu_in_q[11:8];
          rsp_out_d   = alu_out;
          rsp_sign_d  = alu_sign;
          rsp_carr_d  = alu_carr;
          rsp_zero_d  = alu_zero;
`ifdef ALU_OPCHK_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          alu_in_d    = 12'h000;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A pop overrides the IDLE return so back-to-back commands skip IDLE.
    if (pop) begin
`ifdef ALU_OPCHK_EN
      if (!head_legal) begin
        alu_in_d    = alu_in_q;
        rsp_valid_d = 1'b1;
        rsp_op_d    = head[11:8];
        rsp_out_d   = 4'h0;
        rsp_sign_d  = 1'b0;
        rsp_carr_d  = 1'b0;
        rsp_zero_d  = 1'b0;
        rsp_err_d   = 1'b1;
        state_d     = StResp;
      end else
`endif
      begin
        alu_in_d     = head;
        issued_cnt_d = issued_cnt_q + 16'd1;
        settle_d     = '0;
        state_d      = StDrive;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      settle_q     <= '0;
      alu_in_q     <= 12'h000;
      issued_cnt_q <= 16'h0000;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= 4'h0;
      rsp_out_q    <= 4'h0;
      rsp_sign_q   <= 1'b0;
      rsp_carr_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
`ifdef ALU_OPCHK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      settle_q     <= settle_d;
      alu_in_q     <= alu_in_d;
      issued_cnt_q <= issued_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_out_q    <= rsp_out_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_carr_q   <= rsp_carr_d;
      rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_OPCHK_EN
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready  = !full;
  assign alu_in     = alu_in_q;
  assign issued_cnt = issued_cnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_out    = rsp_out_q;
  assign rsp_sign   = rsp_sign_q;
  assign rsp_carr   = rsp_carr_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = !empty || (state_q != StIdle);
`ifdef ALU_OPCHK_EN
  assign rsp_err    = rsp_err_q;
`endif

endmodule
